// File: rtl/display_btn_counter_pkg.sv
// Shared types and constants for the push-button driven six-digit BCD display.
package display_pkg;

  localparam int NUM_DIGITS = 6;
  localparam int SEG_W      = 7;

  typedef logic [3:0] digit_t;
  typedef digit_t [NUM_DIGITS-1:0] digits_t;

  // Active-low segment codes, bit0 = segment a.
  localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9 = 7'h10;

  typedef enum logic [1:0] {
    RPT_IDLE,
    RPT_HOLD,
    RPT_REPEAT
  } rpt_state_e;

endpackage

// File: rtl/display_btn_counter_btn_conditioner.sv
// One active-low push-button: 2-flop synchroniser, debounce and a registered
// one-cycle press strobe on the debounced falling edge.
module btn_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             level_q;
  logic             level_prev;
  logic             press_q;
  logic             armed;
  logic [1:0]       settle;
  logic [CNT_W-1:0] cnt;

  assign level = level_q;
  assign press = press_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0    <= 1'b1;
      sync_p1    <= 1'b1;
      level_q    <= 1'b1;
      level_prev <= 1'b1;
      press_q    <= 1'b0;
      armed      <= 1'b0;
      settle     <= '0;
      cnt        <= '0;
    end else begin
      sync_p0    <= raw;
      sync_p1    <= sync_p0;
      settle     <= {settle[0], 1'b1};
      level_prev <= level_q;
      // Only arm once the real pin has been seen released, so a key held
      // through reset needs a genuine release before it can press.
      if (settle[1] && level_q && sync_p1)
        armed <= 1'b1;
      if (sync_p1 == level_q) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level_q <= sync_p1;
        cnt     <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
      press_q <= armed & level_prev & ~level_q;
    end
  end

endmodule

// File: rtl/display_btn_counter.sv
// Six-digit BCD up/down counter on three keys (inc, dec, clear) with
// hold-to-repeat, driving active-low seven-segment outputs.
module display_btn_counter #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [2:0]  buttons,
  output logic [41:0] hex_out
);

  import display_pkg::*;

  localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
  localparam logic [TMR_W-1:0] RD_LAST = TMR_W'(REPEAT_DELAY - 1);
  localparam logic [TMR_W-1:0] RP_LAST = TMR_W'(REPEAT_PERIOD - 1);

  function automatic digits_t bcd_inc(input digits_t d);
    digits_t r;
    logic    carry;
    r     = d;
    carry = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (carry) begin
        if (r[k] >= 4'd9) begin
          r[k] = 4'd0;
        end else begin
          r[k]  = r[k] + 4'd1;
          carry = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic digits_t bcd_dec(input digits_t d);
    digits_t r;
    logic    borrow;
    r      = d;
    borrow = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (borrow) begin
        if (r[k] == 4'd0 || r[k] > 4'd9) begin
          r[k] = 4'd9;
        end else begin
          r[k]   = r[k] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [SEG_W-1:0] seg_encode(input digit_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return 7'h7F;
    endcase
  endfunction

  logic [2:0] level;
  logic [2:0] press;

  for (genvar b = 0; b < 3; b++) begin : g_btn
    btn_conditioner #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cond (
      .clk  (clk_clk),
      .rst  (reset_reset),
      .raw  (buttons[b]),
      .level(level[b]),
      .press(press[b])
    );
  end

  logic inc_p;
  logic dec_p;
  logic clr_p;
  assign inc_p = press[0];
  assign dec_p = press[1];
  assign clr_p = press[2];

  rpt_state_e       state_q, state_d;
  logic             dir_up_q, dir_up_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic             rpt_step;
  logic             rpt_exit;

  // Leave hold/repeat when the latched key reads released again, or on clear.
  assign rpt_exit = level[dir_up_q ? 2'd0 : 2'd1] | clr_p;

  always_comb begin
    state_d  = state_q;
    dir_up_d = dir_up_q;
    tmr_d    = tmr_q;
    rpt_step = 1'b0;
    case (state_q)
      RPT_IDLE: begin
        if ((inc_p ^ dec_p) && !clr_p) begin
          state_d  = RPT_HOLD;
          dir_up_d = inc_p;
          tmr_d    = '0;
        end
      end
      RPT_HOLD: begin
        if (rpt_exit) begin
          state_d = RPT_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == RD_LAST) begin
          state_d  = RPT_REPEAT;
          rpt_step = 1'b1;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      RPT_REPEAT: begin
        if (rpt_exit) begin
          state_d = RPT_IDLE;
          tmr_d   = '0;
        end else if (tmr_q == RP_LAST) begin
          rpt_step = 1'b1;
          tmr_d    = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end
      default: state_d = RPT_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q  <= RPT_IDLE;
      dir_up_q <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      dir_up_q <= dir_up_d;
      tmr_q    <= tmr_d;
    end
  end

  digits_t cnt_q, cnt_d;
  logic    step_up;
  logic    step_dn;

  // Fresh presses only count from IDLE; while a key is latched the other
  // direction is ignored and steps come from the repeat timer.
  always_comb begin
    step_up = 1'b0;
    step_dn = 1'b0;
    if (state_q == RPT_IDLE) begin
      step_up = inc_p & ~dec_p;
      step_dn = dec_p & ~inc_p;
    end else if (rpt_step) begin
      step_up = dir_up_q;
      step_dn = ~dir_up_q;
    end
    cnt_d = cnt_q;
    if (clr_p)
      cnt_d = '0;
    else if (step_up)
      cnt_d = bcd_inc(cnt_q);
    else if (step_dn)
      cnt_d = bcd_dec(cnt_q);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  logic [NUM_DIGITS*SEG_W-1:0] hex_d;

  always_comb begin
    hex_d = '0;
    for (int k = 0; k < NUM_DIGITS; k++)
      hex_d[k*SEG_W +: SEG_W] = seg_encode(cnt_q[k]);
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset)
      hex_out <= {NUM_DIGITS{SEG_0}};
    else
      hex_out <= hex_d;
  end

endmodule
